// File: rtl/asr_pkg.sv
// Shared types and constants for the keyword-spotting output decision path.
// Provides score geometry, class index width, FSM states and the Q1.15 minimum.
package asr_pkg;

    localparam int NUM_CLASSES = 8;
    localparam int DATA_W      = 16;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DECIDE
    } state_t;

    localparam logic signed [DATA_W-1:0] Q15_MIN =
        {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/class_decision_if.sv
// Frame handshake and per-frame result bundle for class_decision.
// master: upstream producer/consumer side; slave: the decision block.
interface class_decision_if;
    import asr_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_CLASSES*DATA_W-1:0] scores_flat;
    logic                          out_valid;
    logic [CLASS_W-1:0]            out_class;
    logic [DATA_W-1:0]             out_score;
    logic [DATA_W-1:0]             out_margin;
    logic                          detect;
    logic [CLASS_W-1:0]            detect_class;

    modport master (
        output in_valid,
        output scores_flat,
        input  in_ready,
        input  out_valid,
        input  out_class,
        input  out_score,
        input  out_margin,
        input  detect,
        input  detect_class
    );

    modport slave (
        input  in_valid,
        input  scores_flat,
        output in_ready,
        output out_valid,
        output out_class,
        output out_score,
        output out_margin,
        output detect,
        output detect_class
    );

endinterface

// File: rtl/detect_smoother.sv
// Temporal smoother: fires one detect pulse per sustained strong-class run.
// Ports: clk, rst, i_strobe (frame decided), i_idx, i_margin -> o_detect, o_detect_class.
module detect_smoother
    import asr_pkg::*;
#(
    parameter int                 HOLD_FRAMES = 3,
    parameter logic [DATA_W-1:0]  MARGIN_MIN  = 16'd256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_strobe,
    input  logic [CLASS_W-1:0] i_idx,
    input  logic [DATA_W-1:0]  i_margin,
    output logic               o_detect,
    output logic [CLASS_W-1:0] o_detect_class
);

    localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

    logic [CLASS_W-1:0] r_run_class;
    logic [3:0]         r_run_cnt;
    logic               r_fired;

    logic [CLASS_W-1:0] w_class;
    logic [3:0]         w_cnt;
    logic               w_fired;
    logic               w_fire;

    always_comb begin
        w_class = r_run_class;
        w_cnt   = r_run_cnt;
        w_fired = r_fired;
        if (i_margin < MARGIN_MIN) begin
            w_cnt   = 4'd0;
            w_fired = 1'b0;
        end else if (r_run_cnt != 4'd0 && i_idx == r_run_class) begin
            w_cnt = (r_run_cnt >= HOLD) ? HOLD : r_run_cnt + 4'd1;
        end else begin
            w_class = i_idx;
            w_cnt   = 4'd1;
            w_fired = 1'b0;
        end
        // A weak frame leaves the count at 0, which can never equal HOLD.
        w_fire = (w_cnt == HOLD) && !w_fired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_class    <= '0;
            r_run_cnt      <= 4'd0;
            r_fired        <= 1'b0;
            o_detect       <= 1'b0;
            o_detect_class <= '0;
        end else begin
            o_detect <= 1'b0;
            if (i_strobe) begin
                r_run_class <= w_class;
                r_run_cnt   <= w_cnt;
                r_fired     <= w_fired | w_fire;
                if (w_fire) begin
                    o_detect       <= 1'b1;
                    o_detect_class <= w_class;
                end
            end
        end
    end

endmodule

// File: rtl/class_decision.sv
// Output decision stage: serial argmax over one score frame plus detect smoothing.
// Ports: clk, rst (sync, active-high), bus (slave side of class_decision_if).
module class_decision
    import asr_pkg::*;
#(
    parameter int                 HOLD_FRAMES = 3,
    parameter logic [DATA_W-1:0]  MARGIN_MIN  = 16'd256
) (
    input  logic            clk,
    input  logic            rst,
    class_decision_if.slave bus
);

    state_t                    r_state;
    logic [CLASS_W-1:0]        r_k;
    logic signed [DATA_W-1:0]  r_scores [NUM_CLASSES];
    logic signed [DATA_W-1:0]  r_best;
    logic signed [DATA_W-1:0]  r_second;
    logic [CLASS_W-1:0]        r_idx;
    logic                      r_out_valid;
    logic [CLASS_W-1:0]        r_out_class;
    logic [DATA_W-1:0]         r_out_score;
    logic [DATA_W-1:0]         r_out_margin;

    logic signed [DATA_W-1:0]  w_sk;
    logic [DATA_W-1:0]         w_margin;
    logic                      w_decide;

    assign w_sk     = r_scores[r_k];
    // best >= second always, so the 17-bit difference fits 0..65535 and
    // its low 16 bits equal this modular 16-bit difference.
    assign w_margin = r_best - r_second;
    assign w_decide = (r_state == DECIDE);

    assign bus.in_ready   = (r_state == IDLE) && !rst;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_class  = r_out_class;
    assign bus.out_score  = r_out_score;
    assign bus.out_margin = r_out_margin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_best       <= '0;
            r_second     <= '0;
            r_idx        <= '0;
            r_out_valid  <= 1'b0;
            r_out_class  <= '0;
            r_out_score  <= '0;
            r_out_margin <= '0;
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            r_scores[k] <= bus.scores_flat[k*DATA_W +: DATA_W];
                        end
                        r_best   <= bus.scores_flat[DATA_W-1:0];
                        r_second <= Q15_MIN;
                        r_idx    <= '0;
                        r_k      <= CLASS_W'(1);
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    // Strict compares keep the lowest index on ties.
                    if (w_sk > r_best) begin
                        r_second <= r_best;
                        r_best   <= w_sk;
                        r_idx    <= r_k;
                    end else if (w_sk > r_second) begin
                        r_second <= w_sk;
                    end
                    if (r_k == CLASS_W'(NUM_CLASSES-1)) begin
                        r_state <= DECIDE;
                    end else begin
                        r_k <= r_k + CLASS_W'(1);
                    end
                end
                DECIDE: begin
                    r_out_valid  <= 1'b1;
                    r_out_class  <= r_idx;
                    r_out_score  <= r_best;
                    r_out_margin <= w_margin;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    detect_smoother #(
        .HOLD_FRAMES (HOLD_FRAMES),
        .MARGIN_MIN  (MARGIN_MIN)
    ) u_smoother (
        .clk            (clk),
        .rst            (rst),
        .i_strobe       (w_decide),
        .i_idx          (r_idx),
        .i_margin       (w_margin),
        .o_detect       (bus.detect),
        .o_detect_class (bus.detect_class)
    );

endmodule

// File: tb/tb_class_decision.sv
// Directed-vector bench for class_decision: argmax, margin, timing, smoother.
// Expected values are hand-computed constants in the vector table.
module tb_class_decision;

    typedef struct {
        logic [127:0] sc;
        logic [2:0]   cls;
        logic [15:0]  score;
        logic [15:0]  margin;
        logic         det;
        logic [2:0]   dcls;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs [17];

    class_decision_if u_if ();

    class_decision #(
        .HOLD_FRAMES (3),
        .MARGIN_MIN  (16'd256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack8(
        input logic [15:0] s0, input logic [15:0] s1,
        input logic [15:0] s2, input logic [15:0] s3,
        input logic [15:0] s4, input logic [15:0] s5,
        input logic [15:0] s6, input logic [15:0] s7);
        return {s7, s6, s5, s4, s3, s2, s1, s0};
    endfunction

    function automatic logic [127:0] one_hot(input int k,
                                             input logic [15:0] v,
                                             input logic [15:0] rest);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = (i == k) ? v : rest;
        return r;
    endfunction

    task automatic apply(input vec_t v, input int n);
        int w;
        int lat;
        int dets;
        bit seen;
        logic [2:0] held_cls;
        w = 0;
        while (!u_if.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d ready", n), u_if.in_ready, 1);
        u_if.in_valid    = 1'b1;
        u_if.scores_flat = v.sc;
        @(posedge clk);
        #1;
        u_if.in_valid    = 1'b0;
        u_if.scores_flat = ~v.sc;
        lat  = 0;
        dets = 0;
        seen = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (u_if.detect && !u_if.out_valid) dets++;
            if (u_if.out_valid) seen = 1;
        end
        chk($sformatf("v%0d latency", n), lat, 9);
        chk($sformatf("v%0d class", n), u_if.out_class, v.cls);
        chk($sformatf("v%0d score", n), u_if.out_score, v.score);
        chk($sformatf("v%0d margin", n), u_if.out_margin, v.margin);
        chk($sformatf("v%0d detect", n), u_if.detect, v.det);
        chk($sformatf("v%0d dclass", n), u_if.detect_class, v.dcls);
        chk($sformatf("v%0d stray det", n), dets, 0);
        held_cls = u_if.out_class;
        @(negedge clk);
        chk($sformatf("v%0d valid pulse", n), u_if.out_valid, 0);
        chk($sformatf("v%0d det pulse", n), u_if.detect, 0);
        chk($sformatf("v%0d class hold", n), u_if.out_class, v.cls);
        chk($sformatf("v%0d class same", n), held_cls, v.cls);
    endtask

    initial begin
        int nres;
        int ndet;
        logic [127:0] c3, c4, w3;

        c3 = one_hot(3, 16'h0400, 16'h0000);
        c4 = one_hot(4, 16'h0400, 16'h0000);
        w3 = one_hot(3, 16'h0010, 16'h0000);
        vecs[0]  = '{pack8(16'h0100, 16'h7000, 16'h1000, 16'h0, 16'h0,
                           16'h0, 16'h0, 16'h0),
                     3'd1, 16'h7000, 16'h6000, 1'b0, 3'd0};
        vecs[1]  = '{one_hot(0, 16'h8000, 16'h8000),
                     3'd0, 16'h8000, 16'h0000, 1'b0, 3'd0};
        vecs[2]  = '{pack8(16'h0, 16'h0, 16'h4000, 16'h0, 16'h0,
                           16'h4000, 16'h0, 16'h0),
                     3'd2, 16'h4000, 16'h0000, 1'b0, 3'd0};
        vecs[3]  = '{one_hot(7, 16'h7FFF, 16'h8000),
                     3'd7, 16'h7FFF, 16'hFFFF, 1'b0, 3'd0};
        vecs[4]  = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd0};
        vecs[5]  = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd0};
        vecs[6]  = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b1, 3'd3};
        vecs[7]  = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[8]  = '{w3, 3'd3, 16'h0010, 16'h0010, 1'b0, 3'd3};
        vecs[9]  = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[10] = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[11] = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b1, 3'd3};
        vecs[12] = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[13] = '{c3, 3'd3, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[14] = '{c4, 3'd4, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[15] = '{c4, 3'd4, 16'h0400, 16'h0400, 1'b0, 3'd3};
        vecs[16] = '{c4, 3'd4, 16'h0400, 16'h0400, 1'b1, 3'd4};

        u_if.in_valid    = 1'b0;
        u_if.scores_flat = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", u_if.in_ready, 0);
        chk("rst out_valid", u_if.out_valid, 0);
        chk("rst detect", u_if.detect, 0);
        chk("rst out_class", u_if.out_class, 0);
        chk("rst out_score", u_if.out_score, 0);
        chk("rst out_margin", u_if.out_margin, 0);
        chk("rst dclass", u_if.detect_class, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", u_if.in_ready, 1);

        for (int i = 0; i < 17; i++) apply(vecs[i], i);

        // Reset four cycles into a frame abandons it and clears all state.
        @(negedge clk);
        u_if.in_valid    = 1'b1;
        u_if.scores_flat = one_hot(5, 16'h0400, 16'h0000);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan rst in_ready", u_if.in_ready, 0);
        rst  = 1'b0;
        nres = 0;
        ndet = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (u_if.out_valid) nres++;
            if (u_if.detect) ndet++;
        end
        chk("midscan no result", nres, 0);
        chk("midscan no detect", ndet, 0);
        chk("midscan out_class", u_if.out_class, 0);
        chk("midscan dclass", u_if.detect_class, 0);
        chk("midscan in_ready", u_if.in_ready, 1);

        // in_valid held across the busy window yields one result only.
        u_if.in_valid    = 1'b1;
        u_if.scores_flat = one_hot(6, 16'h0020, 16'h0000);
        nres = 0;
        ndet = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (u_if.detect) ndet++;
            if (u_if.out_valid) begin
                nres++;
                chk("held class", u_if.out_class, 6);
                chk("held margin", u_if.out_margin, 16'h0020);
                u_if.in_valid = 1'b0;
            end
        end
        u_if.in_valid = 1'b0;
        chk("held one result", nres, 1);
        chk("held no detect", ndet, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
